// File: rtl/bsg_mem_1rw_sync_mask_write_bit_init.sv
// bsg_mem_1rw_sync_mask_write_bit_init
//
// Single-port synchronous RAM with a per-bit write mask. It has a built-in sweep
// engine that writes init_val_p to every entry after reset, or when clear_i is
// seen while the block is idle.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   reset_i      synchronous, active-high reset (array contents untouched)
//   v_i/ready_o  access handshake; an access is accepted on v_i & ready_o
//   w_i          1 = write, 0 = read
//   addr_i       entry address (ignored when els_p == 1)
//   data_i       write data
//   w_mask_i     per-bit write enable, 1 = bit written
//   clear_i      request a full re-initialization sweep (honoured when ready)
//   data_o       read data, one cycle after the read is accepted
//   v_o          data_o carries the read accepted in the previous cycle
//   init_busy_o  a sweep is in progress

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_mem_1rw_sync_mask_write_bit_init #(
    // width_p and els_p are expected to be set by every instantiation.
    parameter int                 width_p           = 8,
    parameter int                 els_p             = 4,
    parameter logic [width_p-1:0] init_val_p        = '0,
    parameter bit                 init_on_reset_p   = 1'b1,
    parameter bit                 latch_last_read_p = 1'b1,
    parameter int                 addr_width_lp     = `BSG_SAFE_CLOG2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    input  logic                     clear_i,
    output logic [width_p-1:0]       data_o,
    output logic                     v_o,
    output logic                     init_busy_o
);

    localparam bit Degenerate = (width_p == 0) || (els_p == 0);
    localparam int MemEls     = (els_p > 0) ? els_p : 1;
    localparam int MemWidth   = (width_p > 0) ? width_p : 1;
    localparam logic [addr_width_lp-1:0] LastAddr =
        addr_width_lp'((els_p > 0) ? els_p - 1 : 0);

    typedef enum logic [1:0] {
        StReset,
        StInit,
        StReady
    } state_e;

    // A degenerate array has a zero-length sweep, so it goes straight to ready.
    localparam state_e PostResetState =
        (init_on_reset_p && !Degenerate) ? StInit : StReady;

    state_e                   state_q, state_d;
    logic [addr_width_lp-1:0] cnt_q, cnt_d;

    // The reset edge loads the post-reset state directly, so the first cycle
    // with reset_i low already runs the sweep (or is ready). The reset state
    // itself is visible only while reset_i is high.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= PostResetState;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                // Saturate at the last entry rather than wrap.
                if (cnt_q == LastAddr) begin
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: begin
                if (clear_i) begin
                    state_d = Degenerate ? StReady : StInit;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PostResetState;
                cnt_d   = '0;
            end
        endcase
    end

    // Gating by reset_i keeps the handshake quiet for the whole reset window,
    // including the first reset cycle before any edge has been seen.
    assign ready_o     = ~reset_i & (state_q == StReady);
    assign init_busy_o = ~reset_i & (state_q == StInit);

    logic                     acc;
    logic                     init_we;
    logic [addr_width_lp-1:0] acc_addr;
    logic                     addr_ok;
    logic                     unused_addr;

    assign acc         = v_i & ready_o;
    assign init_we     = ~reset_i & (state_q == StInit);
    assign acc_addr    = (els_p == 1) ? '0 : addr_i;
    assign addr_ok     = (32'(acc_addr) < 32'(els_p));
    assign unused_addr = ^addr_i;

    if (Degenerate) begin : g_degenerate
        assign data_o = '0;
        assign v_o    = 1'b0;
    end else begin : g_array
        logic [MemWidth-1:0] mem_q [MemEls];
        logic [MemWidth-1:0] rdata_q;
        logic                v_q;
        logic                wr_en;
        logic                rd_en;

        assign wr_en = acc & w_i & addr_ok;
        assign rd_en = acc & ~w_i;

        always_ff @(posedge clk_i) begin
            if (init_we) begin
                mem_q[cnt_q] <= init_val_p;
            end else if (wr_en) begin
                mem_q[acc_addr] <= (mem_q[acc_addr] & ~w_mask_i) | (data_i & w_mask_i);
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                v_q <= 1'b0;
            end else begin
                v_q <= rd_en;
            end
        end

        if (latch_last_read_p) begin : g_latch
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    rdata_q <= '0;
                end else if (rd_en) begin
                    rdata_q <= addr_ok ? mem_q[acc_addr] : '0;
                end
            end
        end else begin : g_no_latch
            always_ff @(posedge clk_i) begin
                if (rd_en) begin
                    rdata_q <= addr_ok ? mem_q[acc_addr] : '0;
                end
            end
        end

        assign data_o = rdata_q;
        assign v_o    = ~reset_i & v_q;
    end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_init.sv
module tb_bsg_mem_1rw_sync_mask_write_bit_init;

    logic clk;
    int   tests;
    int   fails;

    // Instance A: 8 x 5, sweep to A5 on reset, latched read data.
    logic       a_rst, a_v, a_w, a_clear;
    logic [2:0] a_addr;
    logic [7:0] a_data, a_mask;
    logic       a_ready, a_vo, a_busy;
    logic [7:0] a_dout;

    // Instance B: 8 x 1, no sweep on reset.
    logic       b_rst, b_v, b_w, b_clear;
    logic [0:0] b_addr;
    logic [7:0] b_data, b_mask;
    logic       b_ready, b_vo, b_busy;
    logic [7:0] b_dout;

    bsg_mem_1rw_sync_mask_write_bit_init #(
        .width_p          (8),
        .els_p            (5),
        .init_val_p       (8'hA5),
        .init_on_reset_p  (1'b1),
        .latch_last_read_p(1'b1)
    ) u_a (
        .clk_i      (clk),
        .reset_i    (a_rst),
        .v_i        (a_v),
        .ready_o    (a_ready),
        .w_i        (a_w),
        .addr_i     (a_addr),
        .data_i     (a_data),
        .w_mask_i   (a_mask),
        .clear_i    (a_clear),
        .data_o     (a_dout),
        .v_o        (a_vo),
        .init_busy_o(a_busy)
    );

    bsg_mem_1rw_sync_mask_write_bit_init #(
        .width_p          (8),
        .els_p            (1),
        .init_val_p       (8'h00),
        .init_on_reset_p  (1'b0),
        .latch_last_read_p(1'b1)
    ) u_b (
        .clk_i      (clk),
        .reset_i    (b_rst),
        .v_i        (b_v),
        .ready_o    (b_ready),
        .w_i        (b_w),
        .addr_i     (b_addr),
        .data_i     (b_data),
        .w_mask_i   (b_mask),
        .clear_i    (b_clear),
        .data_o     (b_dout),
        .v_o        (b_vo),
        .init_busy_o(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [2:0] addr, input logic [7:0] d, input logic [7:0] m);
        check("a_wr_ready", {31'd0, a_ready}, 32'd1);
        a_v = 1'b1; a_w = 1'b1; a_addr = addr; a_data = d; a_mask = m;
        tick();
        a_v = 1'b0; a_w = 1'b0;
    endtask

    task automatic a_read(input logic [2:0] addr, input logic [7:0] exp);
        check("a_rd_ready", {31'd0, a_ready}, 32'd1);
        a_v = 1'b1; a_w = 1'b0; a_addr = addr;
        tick();
        a_v = 1'b0;
        check("a_rd_vo", {31'd0, a_vo}, 32'd1);
        check("a_rd_data", {24'd0, a_dout}, {24'd0, exp});
    endtask

    task automatic b_write(input logic [0:0] addr, input logic [7:0] d, input logic [7:0] m);
        b_v = 1'b1; b_w = 1'b1; b_addr = addr; b_data = d; b_mask = m;
        tick();
        b_v = 1'b0; b_w = 1'b0;
    endtask

    task automatic b_read(input logic [0:0] addr, input logic [7:0] exp);
        b_v = 1'b1; b_w = 1'b0; b_addr = addr;
        tick();
        b_v = 1'b0;
        check("b_rd_vo", {31'd0, b_vo}, 32'd1);
        check("b_rd_data", {24'd0, b_dout}, {24'd0, exp});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        a_rst = 1'b1; a_v = 1'b0; a_w = 1'b0; a_clear = 1'b0;
        a_addr = '0; a_data = '0; a_mask = '0;
        b_rst = 1'b1; b_v = 1'b0; b_w = 1'b0; b_clear = 1'b0;
        b_addr = '0; b_data = '0; b_mask = '0;

        // Reset values.
        repeat (3) tick();
        check("a_rst_ready", {31'd0, a_ready}, 32'd0);
        check("a_rst_vo", {31'd0, a_vo}, 32'd0);
        check("a_rst_busy", {31'd0, a_busy}, 32'd0);
        check("a_rst_data", {24'd0, a_dout}, 32'h00);

        // Reset sweep: busy in cycles 0..4, ready from cycle 5.
        a_rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("a_sweep_busy_ready", {30'd0, a_busy, a_ready}, 32'd2);
            tick();
        end
        check("a_sweep_done", {30'd0, a_busy, a_ready}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            a_read(3'(k), 8'hA5);
        end

        // Masked write over A5, then back-to-back write/read.
        a_write(3'd2, 8'hFF, 8'h0F);
        tick();
        a_read(3'd2, 8'hAF);
        a_write(3'd3, 8'hFF, 8'h0F);
        a_read(3'd3, 8'hAF);

        // Latched read data holds while idle.
        a_write(3'd1, 8'h3C, 8'hFF);
        a_read(3'd1, 8'h3C);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("a_latch_vo", {31'd0, a_vo}, 32'd0);
            check("a_latch_data", {24'd0, a_dout}, 32'h3C);
        end

        // clear_i together with a read of addr 1.
        a_write(3'd1, 8'h11, 8'hFF);
        a_clear = 1'b1; a_v = 1'b1; a_w = 1'b0; a_addr = 3'd1;
        tick();
        a_clear = 1'b0; a_v = 1'b0;
        check("a_clr_vo", {31'd0, a_vo}, 32'd1);
        check("a_clr_data", {24'd0, a_dout}, 32'h11);
        // Accesses during the sweep must be ignored; writes target addr 0 after
        // the sweep has already passed it.
        for (int k = 0; k < 5; k++) begin
            check("a_clr_busy_ready", {30'd0, a_busy, a_ready}, 32'd2);
            if (k != 0) check("a_clr_no_vo", {31'd0, a_vo}, 32'd0);
            a_v = 1'b1; a_w = k[0]; a_addr = 3'd0; a_data = 8'h00; a_mask = 8'hFF;
            tick();
        end
        a_v = 1'b0; a_w = 1'b0;
        check("a_clr_done", {30'd0, a_busy, a_ready}, 32'd1);
        check("a_clr_done_vo", {31'd0, a_vo}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            a_read(3'(k), 8'hA5);
        end

        // Reset mid-sweep restarts from address 0.
        a_write(3'd4, 8'h5A, 8'hFF);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("a_mid_busy", {30'd0, a_busy, a_ready}, 32'd2);
            tick();
        end
        a_rst = 1'b1;
        #1;
        check("a_mid_rst_outs", {30'd0, a_busy, a_ready}, 32'd0);
        check("a_mid_rst_data", {24'd0, a_dout}, 32'h00);
        tick();
        a_rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("a_mid_resweep", {30'd0, a_busy, a_ready}, 32'd2);
            tick();
        end
        check("a_mid_done", {30'd0, a_busy, a_ready}, 32'd1);
        a_read(3'd4, 8'hA5);
        a_read(3'd0, 8'hA5);

        // Instance B: no sweep, single entry, addr_i ignored.
        check("b_rst_ready", {31'd0, b_ready}, 32'd0);
        b_rst = 1'b0;
        #1;
        check("b_cycle0_ready", {31'd0, b_ready}, 32'd1);
        check("b_cycle0_busy", {31'd0, b_busy}, 32'd0);
        b_write(1'b1, 8'hC3, 8'hFF);
        b_read(1'b0, 8'hC3);
        b_write(1'b1, 8'h0F, 8'hF0);
        b_read(1'b1, 8'h03);
        // Reset clears read data but not the array.
        b_rst = 1'b1;
        tick();
        check("b_rst_data", {24'd0, b_dout}, 32'h00);
        b_rst = 1'b0;
        #1;
        b_read(1'b0, 8'h03);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
